led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//   Parametrised LED pattern engine: next generation of the 4-bit rotating LED shifter.
//   Generalised to LED_WIDTH bits, programmable step rate via an internal prescaler.
//   Four runtime modes: rotate, bounce, fill, hold. Plus direction control and status pulses.
//   Sits between the board's button/valid logic and the LED pins.
// PARAMETERS
//   LED_WIDTH  4   number of LEDs / pattern bits (>=2)
//   PRESCALE   1   clock cycles per step slot (>=1); 1 = step every cycle i_valid is high
//   PWM_BITS   4   duty resolution, used only with LED_PWM_EN
// PORTS
//   clock      in   1          rising-edge clock
//   i_reset    in   1          synchronous, active-low reset
//   i_valid    in   1          step enable; a step occurs on a cycle with i_valid=1 and prescaler tick
//   i_mode     in   2          mode select (led_pkg: ROTATE=0, BOUNCE=1, FILL=2, HOLD=3)
//   i_dir      in   1          0 = toward MSB (left), 1 = toward LSB (right); ROTATE/FILL only
//   i_duty     in   PWM_BITS   brightness duty; present only with LED_PWM_EN
//   o_led      out  LED_WIDTH  LED drive
//   o_step     out  1          1-cycle pulse, registered with the pattern update
//   o_wrap     out  1          1-cycle pulse when the pattern completes a cycle (see modes)
// BEHAVIOUR
//   Reset (i_reset=0 at posedge): pattern=1 (LSB set), prescaler=0, bounce_dir=left, mode_q=i_mode;
//     o_step=0, o_wrap=0. Reset overrides every other input.
//   Prescaler: counts 0..PRESCALE-1 and wraps; tick when count==PRESCALE-1; free-runs regardless of i_valid.
//   Step = i_valid & tick. Pattern and pulses update in the same edge; latency 1 cycle from step to o_led.
//   ROTATE: circular shift by 1 in i_dir. o_wrap when set bit leaves MSB->LSB (left) or LSB->MSB (right).
//   BOUNCE: single bit walks with internal bounce_dir. At MSB going left, or at LSB going right:
//     reverse bounce_dir and move away on the same step. So LSB,..,MSB,MSB-1,.., with no end repeat.
//     o_wrap on the step that lands on LSB.
//   FILL left: shift in 1 at LSB (0001,0011,0111,1111).
//     From all-ones, next step -> 0001 with o_wrap. Right mirrors from the MSB end (1000,1100,..).
//   HOLD: pattern frozen; steps still pulse o_step, o_wrap=0.
//   Mode change: when i_mode != mode_q at a posedge, mode_q<=i_mode and pattern reloads to its seed.
//     Seed is LSB for left/BOUNCE and MSB for right FILL. bounce_dir<=left, prescaler<=0.
//     No step that cycle, and o_step=o_wrap=0.
//   Direction change in ROTATE/FILL takes effect on the next step; pattern is not reloaded.
//     Mid-FILL reversal continues from the current pattern.
//     If the pattern is not contiguous from the new end, the next step reloads the seed.
//   i_valid=0: pattern held, prescaler keeps counting.
// CONFIGURATION
//   LED_PWM_EN defined: free-running PWM_BITS counter pwm_cnt (reset 0).
//     o_led = pattern & {LED_WIDTH{pwm_cnt < i_duty}}.
//     i_duty=0 gives LEDs always off; max duty gives on (2^PWM_BITS-1)/2^PWM_BITS of the time.
//     o_step and o_wrap are unaffected.
//   LED_PWM_EN undefined: o_led = pattern register directly; i_duty port and pwm_cnt are absent.
// STRUCTURE
//   led_pkg: mode localparams (MODE_ROTATE/BOUNCE/FILL/HOLD), DIR_LEFT/DIR_RIGHT, seed helper function.
//   Sub-module led_tick_prescaler (PRESCALE param; clock, i_reset, i_clear -> o_tick) is instantiated once.
//   Pattern next-state is combinational from mode_q/dir; all outputs are registered.
// TESTING  (LED_WIDTH=4, PRESCALE=1 unless noted)
//   Reset: hold i_reset=0 3 cycles with i_valid=1 -> o_led=0001, o_step=0, o_wrap=0 throughout.
//   ROTATE left, i_valid=1 for 5 steps -> 0010,0100,1000,0001(o_wrap=1),0010; dir=1 from 0010 -> 0001.
//   BOUNCE 8 steps from 0001 -> 0010,0100,1000,0100,0010,0001(wrap),0010,0100.
//   FILL right 5 steps -> seed 1000, then 1100,1110,1111,1000(wrap),1100; mode change mid-run reloads seed.
//   PRESCALE=3, i_valid=1 -> o_step every 3rd cycle; i_valid dropped 1 cycle on a tick -> that step skipped.
//   LED_PWM_EN, PWM_BITS=4: duty 0 -> o_led=0 always; duty 4 -> on 4 of every 16 cycles.
//     Reset mid-PWM -> 0001 next cycle.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: mode and direction encodings plus the seed helper shared by the LED pattern engine.
package led_pkg;
    localparam logic [1:0] MODE_ROTATE = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Only a rightward fill starts from the MSB end; everything else seeds at the LSB.
    function automatic logic seed_is_msb(input logic [1:0] mode, input logic dir);
        return mode == MODE_FILL && dir == DIR_RIGHT;
    endfunction
endpackage

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler: free-running 0..PRESCALE-1 counter; o_tick marks the last count of each slot.
module led_tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_tick = cnt_q == CW'(PRESCALE - 1);
    assign cnt_d  = (i_clear | o_tick) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clock)
        cnt_q <= !i_reset ? '0 : cnt_d;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern engine with rotate/bounce/fill/hold modes and a step prescaler.
// Define LED_PWM_EN to add the i_duty brightness port and the PWM_BITS free-running duty counter.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int LED_WIDTH = 4,
    parameter int PRESCALE  = 1
`ifdef LED_PWM_EN
    , parameter int PWM_BITS = 4
`endif
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [1:0]           i_mode,
    input  logic                 i_dir,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0]  i_duty,
`endif
    output logic [LED_WIDTH-1:0] o_led,
    output logic                 o_step,
    output logic                 o_wrap
);
    localparam logic [LED_WIDTH-1:0] LSB = LED_WIDTH'(1);
    localparam logic [LED_WIDTH-1:0] MSB = LSB << (LED_WIDTH - 1);

    logic [LED_WIDTH-1:0] pat_q, pat_d, seed, fill_l, fill_r, bnc;
    logic [1:0]           mode_q;
    logic                 bdir_q, bdir_d, step_q, wrap_q, wrap_d;
    logic                 tick, chg, step, bturn;

    led_tick_prescaler #(.PRESCALE(PRESCALE)) u_tick (
        .clock  (clock),
        .i_reset(i_reset),
        .i_clear(chg),
        .o_tick (tick)
    );

    assign chg   = i_mode != mode_q;
    assign step  = i_valid & tick & ~chg;
    assign seed  = seed_is_msb(i_mode, i_dir) ? MSB : LSB;
    assign bturn = bdir_q ? pat_q[0] : pat_q[LED_WIDTH-1];
    assign bnc   = (bdir_q ^ bturn) ? pat_q >> 1 : pat_q << 1;
    // A partial fill that no longer hugs the growing end restarts from that end's seed.
    assign fill_l = (!(&pat_q) && (pat_q & (pat_q + LSB)) == '0) ? {pat_q[LED_WIDTH-2:0], 1'b1} : LSB;
    assign fill_r = (!(&pat_q) && (~pat_q & (~pat_q + LSB)) == '0) ? {1'b1, pat_q[LED_WIDTH-1:1]} : MSB;

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            pat_q  <= LSB;
            mode_q <= i_mode;
            bdir_q <= DIR_LEFT;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            mode_q <= i_mode;
            bdir_q <= bdir_d;
            step_q <= step;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        bdir_d = bdir_q;
        wrap_d = 1'b0;
        if (chg) begin
            pat_d  = seed;
            bdir_d = DIR_LEFT;
        end else if (step) begin
            case (mode_q)
                MODE_ROTATE: begin
                    pat_d  = i_dir ? {pat_q[0], pat_q[LED_WIDTH-1:1]} : {pat_q[LED_WIDTH-2:0], pat_q[LED_WIDTH-1]};
                    wrap_d = i_dir ? pat_q[0] : pat_q[LED_WIDTH-1];
                end
                MODE_BOUNCE: begin
                    pat_d  = bnc;
                    bdir_d = bdir_q ^ bturn;
                    wrap_d = bnc == LSB;
                end
                MODE_FILL: begin
                    pat_d  = i_dir ? fill_r : fill_l;
                    wrap_d = &pat_q;
                end
                default: ;
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_q;

    always_ff @(posedge clock)
        pwm_q <= !i_reset ? '0 : pwm_q + 1'b1;

    always_comb o_led = pat_q & {LED_WIDTH{pwm_q < i_duty}};
`else
    always_comb o_led = pat_q;
`endif

    assign o_step = step_q;
    assign o_wrap = wrap_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen (PRESCALE=1 main DUT, PRESCALE=3 second DUT).
module tb_led_pattern_gen;
    import led_pkg::*;

    typedef struct packed {logic [3:0] led; logic step; logic wrap;} exp_t;
    typedef struct packed {logic v; logic [1:0] m; logic d; logic [3:0] l; logic s; logic w;} row_t;

    logic       clock = 1'b0;
    logic       i_reset = 1'b0, valid = 1'b0, dir = 1'b0;
    logic [1:0] mode = MODE_ROTATE;
    logic       rst2 = 1'b0, valid2 = 1'b0, dir2 = 1'b0;
    logic [1:0] mode2 = MODE_ROTATE;
    logic [3:0] led, led2;
    logic       step, wrap, step2, wrap2;
`ifdef LED_PWM_EN
    logic [3:0] duty = 4'hf, duty2 = 4'hf;
`endif
    exp_t q[$];
    exp_t e;
    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    led_pattern_gen dut (
        .clock(clock), .i_reset(i_reset), .i_valid(valid), .i_mode(mode), .i_dir(dir),
`ifdef LED_PWM_EN
        .i_duty(duty),
`endif
        .o_led(led), .o_step(step), .o_wrap(wrap)
    );

    led_pattern_gen #(.PRESCALE(3)) dut3 (
        .clock(clock), .i_reset(rst2), .i_valid(valid2), .i_mode(mode2), .i_dir(dir2),
`ifdef LED_PWM_EN
        .i_duty(duty2),
`endif
        .o_led(led2), .o_step(step2), .o_wrap(wrap2)
    );

    task automatic drive(input row_t r);
        @(negedge clock);
        valid = r.v; mode = r.m; dir = r.d;
        q.push_back({r.l, r.s, r.w});
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive('{1'b1, MODE_ROTATE, 1'b0, 4'b0001, 1'b0, 1'b0});
            e = q.pop_front();
            checks++;
            if ({led, step, wrap} !== e) begin
                failures++;
                $display("FAIL reset[%0d] got led=%b step=%b wrap=%b want led=%b step=%b wrap=%b", i, led, step, wrap, e.led, e.step, e.wrap);
            end
        end
        i_reset = 1'b1; rst2 = 1'b1;
    endtask

    task automatic test_rotate();
        row_t t [8] = '{
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0010, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0100, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b1000, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0001, 1'b1, 1'b1},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0010, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b1, 4'b0001, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b1, 4'b1000, 1'b1, 1'b1},
            '{1'b0, MODE_ROTATE, 1'b1, 4'b1000, 1'b0, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            drive(t[i]);
            e = q.pop_front();
            checks++;
            if ({led, step, wrap} !== e) begin
                failures++;
                $display("FAIL rotate[%0d] got led=%b step=%b wrap=%b want led=%b step=%b wrap=%b", i, led, step, wrap, e.led, e.step, e.wrap);
            end
        end
    endtask

    task automatic test_bounce();
        row_t t [10] = '{
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0001, 1'b0, 1'b0},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0010, 1'b1, 1'b0},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0100, 1'b1, 1'b0},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b1000, 1'b1, 1'b0},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0100, 1'b1, 1'b0},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0010, 1'b1, 1'b0},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0001, 1'b1, 1'b1},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0010, 1'b1, 1'b0},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0100, 1'b1, 1'b0},
            '{1'b0, MODE_BOUNCE, 1'b0, 4'b0100, 1'b0, 1'b0}};
        for (int i = 0; i < 10; i++) begin
            drive(t[i]);
            e = q.pop_front();
            checks++;
            if ({led, step, wrap} !== e) begin
                failures++;
                $display("FAIL bounce[%0d] got led=%b step=%b wrap=%b want led=%b step=%b wrap=%b", i, led, step, wrap, e.led, e.step, e.wrap);
            end
        end
    endtask

    task automatic test_fill();
        row_t t [11] = '{
            '{1'b1, MODE_FILL,   1'b1, 4'b1000, 1'b0, 1'b0},
            '{1'b1, MODE_FILL,   1'b1, 4'b1100, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b1, 4'b1110, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b1, 4'b1111, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b1, 4'b1000, 1'b1, 1'b1},
            '{1'b1, MODE_FILL,   1'b1, 4'b1100, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b0, 4'b0001, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b0, 4'b0011, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b0, 4'b0111, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b1, 4'b1000, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b1, 4'b0001, 1'b0, 1'b0}};
        for (int i = 0; i < 11; i++) begin
            drive(t[i]);
            e = q.pop_front();
            checks++;
            if ({led, step, wrap} !== e) begin
                failures++;
                $display("FAIL fill[%0d] got led=%b step=%b wrap=%b want led=%b step=%b wrap=%b", i, led, step, wrap, e.led, e.step, e.wrap);
            end
        end
    endtask

    task automatic test_hold();
        row_t t [3] = '{
            '{1'b1, MODE_HOLD, 1'b0, 4'b0001, 1'b0, 1'b0},
            '{1'b1, MODE_HOLD, 1'b0, 4'b0001, 1'b1, 1'b0},
            '{1'b1, MODE_HOLD, 1'b1, 4'b0001, 1'b1, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            drive(t[i]);
            e = q.pop_front();
            checks++;
            if ({led, step, wrap} !== e) begin
                failures++;
                $display("FAIL hold[%0d] got led=%b step=%b wrap=%b want led=%b step=%b wrap=%b", i, led, step, wrap, e.led, e.step, e.wrap);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t t [8] = '{
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0001, 1'b0, 1'b0},
            '{1'b1, MODE_FILL,   1'b1, 4'b1000, 1'b0, 1'b0},
            '{1'b1, MODE_BOUNCE, 1'b0, 4'b0001, 1'b0, 1'b0},
            '{1'b1, MODE_FILL,   1'b0, 4'b0001, 1'b0, 1'b0},
            '{1'b1, MODE_FILL,   1'b0, 4'b0011, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b0, 4'b0111, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b0, 4'b1111, 1'b1, 1'b0},
            '{1'b1, MODE_FILL,   1'b0, 4'b0001, 1'b1, 1'b1}};
        for (int i = 0; i < 8; i++) begin
            drive(t[i]);
            e = q.pop_front();
            checks++;
            if ({led, step, wrap} !== e) begin
                failures++;
                $display("FAIL b2b[%0d] got led=%b step=%b wrap=%b want led=%b step=%b wrap=%b", i, led, step, wrap, e.led, e.step, e.wrap);
            end
        end
    endtask

    task automatic test_prescale();
        row_t t [16] = '{
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0001, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0001, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0001, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0010, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0010, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0010, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0100, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0100, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0100, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b1000, 1'b1, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b1000, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b1000, 1'b0, 1'b0},
            '{1'b0, MODE_ROTATE, 1'b0, 4'b1000, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b1000, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b1000, 1'b0, 1'b0},
            '{1'b1, MODE_ROTATE, 1'b0, 4'b0001, 1'b1, 1'b1}};
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            rst2 = i != 0;
            valid2 = t[i].v;
            q.push_back({t[i].l, t[i].s, t[i].w});
            @(posedge clock); #1;
            e = q.pop_front();
            checks++;
            if ({led2, step2, wrap2} !== e) begin
                failures++;
                $display("FAIL prescale[%0d] got led=%b step=%b wrap=%b want led=%b step=%b wrap=%b", i, led2, step2, wrap2, e.led, e.step, e.wrap);
            end
        end
        rst2 = 1'b1;
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        int on_cnt;
        duty = 4'd0;
        for (int i = 0; i < 16; i++) begin
            drive('{1'b0, MODE_HOLD, 1'b0, 4'b0000, 1'b0, 1'b0});
            e = q.pop_front();
            checks++;
            if ({led, step, wrap} !== e) begin
                failures++;
                $display("FAIL pwm_duty0[%0d] got led=%b want led=%b", i, led, e.led);
            end
        end
        duty = 4'd4;
        i_reset = 1'b0;
        drive('{1'b0, MODE_HOLD, 1'b0, 4'b0001, 1'b0, 1'b0});
        i_reset = 1'b1;
        e = q.pop_front();
        checks++;
        if ({led, step, wrap} !== e) begin
            failures++;
            $display("FAIL pwm_reset got led=%b want led=%b", led, e.led);
        end
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            if (led == 4'b0001) on_cnt++;
        end
        checks++;
        if (on_cnt !== 4) begin
            failures++;
            $display("FAIL pwm_duty4 got on=%0d want on=4", on_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rotate();
        test_bounce();
        test_fill();
        test_hold();
        test_back_to_back();
        test_prescale();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
